kernel_sched: RTL
=================

Name: kernel_sched

Overview:
- Sequencer that streams a grey-scale image from pixel memory through the Kernel convolution unit, one valid (non-border) output pixel at a time.
- Fetches pixels, builds the 3x3 window in column-shift registers and drives it on k_rows with the latched k_sel.
- Captures k_result and writes it to result memory with a ready/valid-style write handshake.
- Sits between the data cache/pixel RAM and the EXE-stage Kernel; started by the control unit.

Parameters:
- IMG_W, 8, image width in pixels (>=3)
- IMG_H, 8, image height in pixels (>=3)
- AW, 16, address width of both memories
- IN_BASE, 0, word address of pixel (0,0) in pixel memory, row-major
- OUT_BASE, 16'h8000, word address of the first result in result memory

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- ksel_in  in  2  kernel select, latched when start is accepted
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of pass
- mem_rd  out  1  pixel read strobe
- mem_addr  out  AW  pixel read address
- mem_rdata  in  8  pixel data, valid exactly 1 cycle after mem_rd
- k_rows  out  3x24  window rows to Kernel; row i = {left[23:16], centre[15:8], right[7:0]}
- k_sel  out  2  kernel select to Kernel
- k_result  in  16  combinational Kernel result
- out_we  out  1  result write valid
- out_ready  in  1  result memory accepts write this cycle
- out_addr  out  AW  result address
- out_data  out  16  result value

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mem_rd, out_we = 0; mem_addr, out_addr, out_data, k_rows, k_sel = 0; row/col counters = 1. Reset mid-pass aborts immediately, with no further reads or writes.
- Output pixel (r,c) is produced for r in 1..IMG_H-2 and c in 1..IMG_W-2, in raster order. There are (IMG_W-2)*(IMG_H-2) writes per pass.
- Pixel address = IN_BASE + y*IMG_W + x.
- Result address = OUT_BASE + (r-1)*(IMG_W-2) + (c-1).
- States:
  - IDLE: when start=1, latch ksel_in into k_sel, set r=c=1, raise busy, and go to FILL.
  - FILL, 10 cycles: cycles 1-9 each issue one read, for columns c-1, c, c+1 in order, rows r-1, r, r+1 within each column. The pixel returned for each read is captured the next cycle (cycles 2-10). On each captured column completion, each row register shifts left 8 and the new pixel enters [7:0]. Then go to CALC.
  - CALC: k_rows stable; out_we=1, out_data=k_result, out_addr as above. Hold (window, data and address stable) until out_ready=1. On acceptance:
    - if c<IMG_W-2: c++ and go to SHIFT;
    - else if r<IMG_H-2: r++, c=1 and go to FILL;
    - else go to DONE.
  - SHIFT, 4 cycles: cycles 1-3 issue reads for column c+1, rows r-1..r+1. Captures occur in cycles 2-4, and the shift is applied after the third capture. Then go to CALC.
  - DONE: done=1 for one cycle, busy=0 on exit to IDLE.
- mem_rd is high only on issue cycles; mem_addr holds its last value otherwise.
- k_rows changes only on capture; the Kernel is never presented a partially updated window in CALC.
- start while busy is ignored; ksel_in changes mid-pass have no effect.
- Counter wrap: none; counters are bounded by IMG_W/IMG_H, with IMG_W=IMG_H=3 giving exactly one output.
- out_ready held low indefinitely stalls in CALC with no reads issued.

Test Plan:
- IMG_W=IMG_H=3, all pixels 11, ksel_in=00, out_ready=1, start pulse at cycle 0 -> 9 reads at addresses 0,3,6,1,4,7,2,5,8 in cycles 1-9; out_we in cycle 11 with out_addr=OUT_BASE and out_data=16'd11; done pulse in cycle 12.
- Same 3x3 image with centre=15 and ksel_in=01 -> single write of 16'd31. With centre=22 and ksel_in=10 -> single write of 16'd110.
- IMG_W=4, IMG_H=3, ramp image pixel=x -> 2 writes, the second 5 cycles after the first. Second window rows each equal {1,2,3}, and out_addr values are OUT_BASE and OUT_BASE+1.
- out_ready low for 7 cycles during the first CALC -> out_we, out_addr and out_data held for 8 cycles; no mem_rd during the stall; final results unchanged.
- rst_n asserted during SHIFT, then released, then start -> all outputs 0 immediately on reset; the new pass restarts at r=c=1 with a full FILL.
- start pulsed while busy, with ksel_in changed -> ignored; results use the originally latched k_sel, and there is exactly one done pulse.

Source files
------------

// File: rtl/kernel_sched_if.sv
// Handshake bundle between kernel_sched, pixel memory, the Kernel unit and result memory.
interface kernel_sched_if #(
    parameter int AW = 16
);
    logic                 start;
    logic [1:0]           ksel_in;
    logic                 busy;
    logic                 done;
    logic                 mem_rd;
    logic [AW-1:0]        mem_addr;
    logic [7:0]           mem_rdata;
    logic [2:0][23:0]     k_rows;
    logic [1:0]           k_sel;
    logic [15:0]          k_result;
    logic                 out_we;
    logic                 out_ready;
    logic [AW-1:0]        out_addr;
    logic [15:0]          out_data;

    modport slave (
        input  start, ksel_in, mem_rdata, k_result, out_ready,
        output busy, done, mem_rd, mem_addr, k_rows, k_sel, out_we, out_addr, out_data
    );

    modport master (
        output start, ksel_in, mem_rdata, k_result, out_ready,
        input  busy, done, mem_rd, mem_addr, k_rows, k_sel, out_we, out_addr, out_data
    );
endinterface

// File: rtl/kernel_sched.sv
// Streams a grey-scale image through the 3x3 Kernel unit, building each window in
// column-shift registers and writing one result per interior pixel.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | 9 reads + captures to build a fresh window at the start of a row
// CALC  | window stable, result write offered until out_ready
// SHIFT | 3 reads + captures to slide the window one column right
// DONE  | one-cycle done pulse
module kernel_sched #(
    parameter int            IMG_W    = 8,
    parameter int            IMG_H    = 8,
    parameter int            AW       = 16,
    parameter logic [AW-1:0] IN_BASE  = '0,
    parameter logic [AW-1:0] OUT_BASE = 16'h8000
) (
    input  logic           clk,
    input  logic           rst_n,
    kernel_sched_if.slave  bus
);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TWO = AW'(2);
    localparam logic [AW-1:0] W_A = AW'(IMG_W);
    localparam logic [AW-1:0] H_A = AW'(IMG_H);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CALC, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_cnt;
    logic [AW-1:0]    r_r, r_c;
    logic [1:0]       r_ro, r_co, r_cro;
    logic [7:0]       r_p0, r_p1;
    logic [2:0][23:0] r_rows;
    logic [1:0]       r_ksel;
    logic [AW-1:0]    r_addr_hold;

    logic             w_rd, w_cap;
    logic [AW-1:0]    w_col, w_row, w_rd_addr, w_out_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FILL;
            S_FILL: begin
                w_rd  = (r_cnt < 4'd9);
                w_cap = (r_cnt != 4'd0);
                if (r_cnt == 4'd9) w_state_nxt = S_CALC;
            end
            S_SHIFT: begin
                w_rd  = (r_cnt < 4'd3);
                w_cap = (r_cnt != 4'd0);
                if (r_cnt == 4'd3) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (bus.out_ready) begin
                    if (r_c < W_A - TWO)      w_state_nxt = S_SHIFT;
                    else if (r_r < H_A - TWO) w_state_nxt = S_FILL;
                    else                      w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FILL walks columns c-1..c+1; SHIFT only ever needs the new right-hand column c+1
    assign w_col      = (r_state == S_FILL) ? (r_c - ONE + AW'(r_co)) : (r_c + ONE);
    assign w_row      = r_r - ONE + AW'(r_ro);
    assign w_rd_addr  = IN_BASE + w_row * W_A + w_col;
    assign w_out_addr = OUT_BASE + (r_r - ONE) * (W_A - TWO) + (r_c - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_r         <= ONE;
            r_c         <= ONE;
            r_ro        <= '0;
            r_co        <= '0;
            r_cro       <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_rows      <= '0;
            r_ksel      <= '0;
            r_addr_hold <= '0;
        end else begin
            if (w_rd) begin
                r_addr_hold <= w_rd_addr;
                if (r_ro == 2'd2) begin
                    r_ro <= '0;
                    r_co <= r_co + 2'd1;
                end else begin
                    r_ro <= r_ro + 2'd1;
                end
            end
            // top and middle pixels are staged so the window updates a whole column at once
            if (w_cap) begin
                case (r_cro)
                    2'd0:    r_p0 <= bus.mem_rdata;
                    2'd1:    r_p1 <= bus.mem_rdata;
                    default: begin
                        r_rows[0] <= {r_rows[0][15:0], r_p0};
                        r_rows[1] <= {r_rows[1][15:0], r_p1};
                        r_rows[2] <= {r_rows[2][15:0], bus.mem_rdata};
                    end
                endcase
                r_cro <= (r_cro == 2'd2) ? 2'd0 : r_cro + 2'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ksel <= bus.ksel_in;
                        r_r    <= ONE;
                        r_c    <= ONE;
                        r_cnt  <= '0;
                        r_ro   <= '0;
                        r_co   <= '0;
                        r_cro  <= '0;
                    end
                end
                S_FILL, S_SHIFT: r_cnt <= r_cnt + 4'd1;
                S_CALC: begin
                    if (bus.out_ready) begin
                        r_cnt <= '0;
                        r_ro  <= '0;
                        r_co  <= '0;
                        r_cro <= '0;
                        if (r_c < W_A - TWO) begin
                            r_c <= r_c + ONE;
                        end else if (r_r < H_A - TWO) begin
                            r_r <= r_r + ONE;
                            r_c <= ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.mem_rd   = w_rd;
    assign bus.mem_addr = w_rd ? w_rd_addr : r_addr_hold;
    assign bus.k_rows   = r_rows;
    assign bus.k_sel    = r_ksel;
    assign bus.out_we   = (r_state == S_CALC);
    assign bus.out_addr = (r_state == S_CALC) ? w_out_addr : '0;
    assign bus.out_data = (r_state == S_CALC) ? bus.k_result : '0;
endmodule
